gated_reg_bank: RTL and testbench

GATED_REG_BANK -- requirements
Module: gated_reg_bank

---
 rtl/gated_reg_bank_pkg.sv | 12 +
 rtl/gated_reg_bank_idle.sv | 32 +++
 rtl/gated_reg_bank.sv | 94 +++++++++
 tb/tb_gated_reg_bank.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/gated_reg_bank_pkg.sv
// Shared constants for the gated register bank: MODE encoding and default sizing.
package gated_reg_bank_pkg;

    localparam logic MODE_LOAD  = 1'b0;
    localparam logic MODE_SHIFT = 1'b1;

    localparam int unsigned DEF_NCH         = 5;
    localparam int unsigned DEF_WIDTH       = 5;
    localparam int unsigned DEF_IDLE_CYCLES = 4;
    localparam int unsigned DEF_SCW         = 16;

endpackage

// File: rtl/gated_reg_bank_idle.sv
// Per-channel idle counter; requests clock gating once the channel has been idle long enough.
module gate_idle_counter
    import gated_reg_bank_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic gate_req
);

    localparam int unsigned CW = $clog2(IDLE_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(IDLE_CYCLES);

    logic [CW-1:0] idle_cnt;

    // Activity clears the count; idleness counts up and parks at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (en) begin
            idle_cnt <= '0;
        end else if (idle_cnt != LIMIT) begin
            idle_cnt <= idle_cnt + CW'(1);
        end
    end

    // Request is a pure decode of the registered count, so waking costs one cycle.
    assign gate_req = (idle_cnt == LIMIT);

endmodule

// File: rtl/gated_reg_bank.sv
// Two mirrored banks of per-channel registers with idle-based gate requests and a
// saturating statistic of gated channel-cycles. No clocks are gated in here; the
// requests are exported for an external clock-gating cell.
module gated_reg_bank
    import gated_reg_bank_pkg::*;
#(
    parameter int unsigned NCH         = DEF_NCH,
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int unsigned SCW         = DEF_SCW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NCH-1:0]             en,
    input  logic                       mode,
    input  logic [WIDTH-1:0]           d_in,
    input  logic                       clr_stats,
    output logic [NCH*WIDTH-1:0]       out1,
    output logic [NCH*WIDTH-1:0]       out2,
    output logic [NCH-1:0]             gate_req,
    output logic [$clog2(NCH+1)-1:0]   gated_cnt,
    output logic [SCW-1:0]             saved_cycles
);

    localparam int unsigned GCW = $clog2(NCH + 1);
    localparam int unsigned SW  = ((SCW > GCW) ? SCW : GCW) + 1;
    localparam logic [SW-1:0] SAT = SW'({SCW{1'b1}});

    logic [SW-1:0] sum_c;

    // Slot update: load the shared word, or shift left taking d[0] into bit 0.
    // For WIDTH=1 the shift leaves only the incoming bit, i.e. a load of d[0].
    function automatic logic [WIDTH-1:0] next_slot(input logic [WIDTH-1:0] cur,
                                                   input logic             m,
                                                   input logic [WIDTH-1:0] d);
        if (m == MODE_SHIFT) begin
            return (cur << 1) | WIDTH'(d[0]);
        end
        return d;
    endfunction

    // Bank A follows en[i]; bank B follows the mirrored enable en[NCH-1-i].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1 <= '0;
            out2 <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (en[i]) begin
                    out1[i*WIDTH +: WIDTH] <= next_slot(out1[i*WIDTH +: WIDTH], mode, d_in);
                end
                if (en[NCH-1-i]) begin
                    out2[i*WIDTH +: WIDTH] <= next_slot(out2[i*WIDTH +: WIDTH], mode, d_in);
                end
            end
        end
    end

    // One idle tracker per channel.
    for (genvar g = 0; g < NCH; g++) begin : g_idle
        gate_idle_counter #(
            .IDLE_CYCLES (IDLE_CYCLES)
        ) u_idle (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[g]),
            .gate_req (gate_req[g])
        );
    end

    // Population count of active gate requests.
    always_comb begin
        gated_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            gated_cnt = gated_cnt + GCW'(gate_req[i]);
        end
    end

    assign sum_c = SW'(saved_cycles) + SW'(gated_cnt);

    // Saturating accumulation of gated channel-cycles; clear wins over accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saved_cycles <= '0;
        end else if (clr_stats) begin
            saved_cycles <= '0;
        end else if (sum_c > SAT) begin
            saved_cycles <= '1;
        end else begin
            saved_cycles <= SCW'(sum_c);
        end
    end

endmodule

// File: tb/tb_gated_reg_bank.sv
// Self-checking bench for gated_reg_bank: reference model feeds a scoreboard queue.
module tb_gated_reg_bank;

    localparam int unsigned NCH  = 5;
    localparam int unsigned W    = 5;
    localparam int unsigned IDLE = 4;
    localparam int unsigned SCW  = 4;
    localparam int unsigned SMAX = 15;

    typedef struct packed {
        logic [NCH*W-1:0] o1;
        logic [NCH*W-1:0] o2;
        logic [NCH-1:0]   gr;
        logic [2:0]       gc;
        logic [SCW-1:0]   sc;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic [NCH-1:0]     en;
    logic               mode;
    logic [W-1:0]       d_in;
    logic               clr_stats;
    logic [NCH*W-1:0]   out1;
    logic [NCH*W-1:0]   out2;
    logic [NCH-1:0]     gate_req;
    logic [2:0]         gated_cnt;
    logic [SCW-1:0]     saved_cycles;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m1 [NCH];
    logic [W-1:0] m2 [NCH];
    int           midle [NCH];
    int           msaved;
    exp_t         sb_q [$];

    gated_reg_bank #(
        .NCH         (NCH),
        .WIDTH       (W),
        .IDLE_CYCLES (IDLE),
        .SCW         (SCW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .d_in         (d_in),
        .clr_stats    (clr_stats),
        .out1         (out1),
        .out2         (out2),
        .gate_req     (gate_req),
        .gated_cnt    (gated_cnt),
        .saved_cycles (saved_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m1[i] = '0;
            m2[i] = '0;
            midle[i] = 0;
        end
        msaved = 0;
    endtask

    function automatic logic [W-1:0] model_slot(input logic [W-1:0] cur, input logic m,
                                                input logic [W-1:0] d);
        if (m) return {cur[W-2:0], d[0]};
        return d;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        int   n;
        n = 0;
        for (int i = 0; i < NCH; i++) begin
            e.o1[i*W +: W] = m1[i];
            e.o2[i*W +: W] = m2[i];
            e.gr[i]        = (midle[i] == IDLE);
            if (midle[i] == IDLE) n++;
        end
        e.gc = 3'(n);
        e.sc = SCW'(msaved);
        return e;
    endfunction

    task automatic model_step(input logic [NCH-1:0] e, input logic m, input logic [W-1:0] d,
                              input logic c);
        int gc;
        gc = 0;
        for (int i = 0; i < NCH; i++) if (midle[i] == IDLE) gc++;
        for (int i = 0; i < NCH; i++) begin
            if (e[i])       m1[i] = model_slot(m1[i], m, d);
            if (e[NCH-1-i]) m2[i] = model_slot(m2[i], m, d);
            if (e[i])              midle[i] = 0;
            else if (midle[i] < IDLE) midle[i] = midle[i] + 1;
        end
        if (c)                          msaved = 0;
        else if (msaved + gc > SMAX)    msaved = SMAX;
        else                            msaved = msaved + gc;
    endtask

    // Drive one cycle, predict it, then compare the DUT output against the queued prediction.
    task automatic step(input logic [NCH-1:0] e, input logic m, input logic [W-1:0] d,
                        input logic c);
        exp_t x;
        en = e; mode = m; d_in = d; clr_stats = c;
        @(posedge clk);
        model_step(e, m, d, c);
        sb_q.push_back(snapshot());
        #1;
        x = sb_q.pop_front();
        check("out1", 32'(out1), 32'(x.o1));
        check("out2", 32'(out2), 32'(x.o2));
        check("gate_req", 32'(gate_req), 32'(x.gr));
        check("gated_cnt", 32'(gated_cnt), 32'(x.gc));
        check("saved_cycles", 32'(saved_cycles), 32'(x.sc));
    endtask

    initial begin
        logic [NCH*W-1:0] all_c;

        rst_n = 1'b0; en = '0; mode = 1'b0; d_in = '0; clr_stats = 1'b0;
        model_reset();
        #12;
        check("rst_out1", 32'(out1), 32'h0);
        check("rst_out2", 32'(out2), 32'h0);
        check("rst_gate", 32'(gate_req), 32'h0);
        check("rst_cnt", 32'(gated_cnt), 32'h0);
        check("rst_saved", 32'(saved_cycles), 32'h0);
        rst_n = 1'b1;

        // Idle from reset: gating after exactly IDLE edges, stats 10 after six.
        for (int k = 1; k <= 6; k++) begin
            step('0, 1'b0, '0, 1'b0);
            if (k == 3) check("idle3_gate", 32'(gate_req), 32'h00);
            if (k == 4) check("idle4_gate", 32'(gate_req), 32'h1F);
        end
        check("idle6_cnt", 32'(gated_cnt), 32'd5);
        check("idle6_saved", 32'(saved_cycles), 32'd10);

        // Parallel load on channel 0 lands in bank A slot 0 and bank B slot 4.
        step(5'b00001, 1'b0, 5'h15, 1'b0);
        check("load_out1", 32'(out1), 32'h15);
        check("load_out2", 32'(out2), 32'h15 << 20);

        // Serial shift on channel 2: bits 1,0,1 give 5'b00101 in both banks' slot 2.
        step(5'b00100, 1'b1, 5'h01, 1'b0);
        step(5'b00100, 1'b1, 5'h1E, 1'b0);
        step(5'b00100, 1'b1, 5'h03, 1'b0);
        check("shift_out1", 32'(out1[14:10]), 32'h05);
        check("shift_out2", 32'(out2[14:10]), 32'h05);

        // Wake a gated channel: write lands, request drops, re-asserts after IDLE idle edges.
        check("ch3_gated", 32'(gate_req[3]), 32'h1);
        step(5'b01000, 1'b0, 5'h0A, 1'b0);
        check("wake_out1", 32'(out1[19:15]), 32'h0A);
        check("wake_out2", 32'(out2[9:5]), 32'h0A);
        check("wake_drop", 32'(gate_req[3]), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step('0, 1'b0, '0, 1'b0);
            if (k == 3) check("wake_idle3", 32'(gate_req[3]), 32'h0);
            if (k == 4) check("wake_idle4", 32'(gate_req[3]), 32'h1);
        end

        // Saturation of the statistic, clear priority, then resumed accumulation.
        for (int k = 0; k < 8; k++) step('0, 1'b0, '0, 1'b0);
        check("sat_hold", 32'(saved_cycles), 32'd15);
        step('0, 1'b0, '0, 1'b1);
        check("clr_zero", 32'(saved_cycles), 32'd0);
        step('0, 1'b0, '0, 1'b0);
        check("clr_resume", 32'(saved_cycles), 32'd5);

        // All channels at once, then random traffic.
        step('1, 1'b0, 5'h13, 1'b0);
        for (int k = 0; k < 150; k++) begin
            step(NCH'($urandom), 1'($urandom), W'($urandom), ($urandom_range(0, 15) == 0));
        end
        step('1, 1'b0, 5'h1F, 1'b0);

        // Asynchronous reset between edges while a full write is pending.
        en = '1; mode = 1'b0; d_in = 5'h0C; clr_stats = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out1", 32'(out1), 32'h0);
        check("arst_out2", 32'(out2), 32'h0);
        check("arst_saved", 32'(saved_cycles), 32'h0);
        @(posedge clk);
        #1;
        check("arst_nowrite", 32'(out1), 32'h0);
        check("arst_gate", 32'(gate_req), 32'h0);
        rst_n = 1'b1;
        model_reset();
        step('1, 1'b0, 5'h0C, 1'b0);
        all_c = {NCH{5'h0C}};
        check("post_rst_write", 32'(out1), 32'(all_c));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
